tt_sel_ctrl: RTL

Design-selection controller that drives the select/enable portion of the vertical spine feeding the row muxes. It turns pad-level requests into a glitch-free spine address and enable. The requests are a clear level, an increment pulse train and an enable level. Every address change uses break-before-make: enable drops, the address settles, then enable returns. This keeps any two user modules from ever driving the spine output bus at the same time.

---
 rtl/tt_sel_ctrl_pkg.sv | 30 +++
 rtl/tt_sync_edge.sv | 33 +++
 rtl/tt_sel_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tt_sel_ctrl_pkg.sv
// Shared definitions for the design-selection controller: FSM encoding,
// spine select width and address field positions.
package tt_sel_ctrl_pkg;

    localparam int TT_SEL_W = 9;

    // Spine select fields: row [8:5], group [4:2], module [1:0]
    localparam int ROW_MSB = 8;
    localparam int ROW_LSB = 5;
    localparam int GRP_MSB = 4;
    localparam int GRP_LSB = 2;
    localparam int MOD_MSB = 1;
    localparam int MOD_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DISABLE = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ENABLE  = 3'd4
    } sel_state_t;

    // Width of a down-counter that is loaded with max(a,b)-1
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pad, followed by a registered
// rising-edge detector producing a single-cycle pulse.
module tt_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              rise_r;

    // Synchronizer chain and edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], pad};
            prev_r <= sync_r[STAGES-1];
            rise_r <= sync_r[STAGES-1] & ~prev_r;
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = rise_r;

endmodule

// File: rtl/tt_sel_ctrl.sv
// Spine select controller: tracks the requested address and applies it with
// break-before-make sequencing of spine_ena around every address change.
module tt_sel_ctrl
    import tt_sel_ctrl_pkg::*;
#(
    parameter int N_SEL         = TT_SEL_W,
    parameter int SYNC_STAGES   = 2,
    parameter int GUARD_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_sel_clr,
    input  logic             pad_sel_inc,
    input  logic             pad_ena,
    output logic [N_SEL-1:0] spine_sel,
    output logic             spine_ena,
    output logic             busy,
    output logic [N_SEL-1:0] target_sel
);

    localparam int               CNT_W       = cnt_width(GUARD_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [N_SEL-1:0] SEL_ONE     = N_SEL'(1);

    logic             clr_s;
    logic             inc_p_s;
    logic             ena_s;
    logic             clr_rise_unused_s;
    logic             inc_level_unused_s;
    logic             ena_rise_unused_s;

    logic [N_SEL-1:0] tgt_r;
    sel_state_t       state_r;
    sel_state_t       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [N_SEL-1:0] sel_r;
    logic [N_SEL-1:0] sel_nx_s;
    logic             ena_r;
    logic             ena_nx_s;
    logic             busy_r;
    logic             busy_nx_s;

    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
        .clk(clk), .rst(rst), .pad(pad_sel_clr), .level(clr_s), .rise(clr_rise_unused_s)
    );
    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_inc (
        .clk(clk), .rst(rst), .pad(pad_sel_inc), .level(inc_level_unused_s), .rise(inc_p_s)
    );
    tt_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ena (
        .clk(clk), .rst(rst), .pad(pad_ena), .level(ena_s), .rise(ena_rise_unused_s)
    );

    // Target address register; clear dominates increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_r <= '0;
        end else if (clr_s) begin
            tgt_r <= '0;
        end else if (inc_p_s) begin
            tgt_r <= tgt_r + SEL_ONE;
        end else begin
            tgt_r <= tgt_r;
        end
    end

    // FSM state, shared guard/settle counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            sel_r   <= '0;
            ena_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            sel_r   <= sel_nx_s;
            ena_r   <= ena_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (tgt_r != sel_r) begin
                    state_nx_s = ST_DISABLE;
                    cnt_nx_s   = GUARD_LOAD;
                end else if (ena_s && !ena_r) begin
                    state_nx_s = ST_ENABLE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DISABLE: begin
                if (cnt_r == '0) begin
                    state_nx_s = ST_SWITCH;
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            ST_SWITCH: begin
                state_nx_s = ST_SETTLE;
                cnt_nx_s   = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                // A target that moved during settling is switched directly:
                // the enable is already low, so no new guard period is needed
                if (cnt_r != '0) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else if (tgt_r != sel_r) begin
                    state_nx_s = ST_SWITCH;
                end else begin
                    state_nx_s = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Output next values; the address is loaded on entry to SWITCH
    always_comb begin
        sel_nx_s  = sel_r;
        ena_nx_s  = 1'b0;
        busy_nx_s = (state_nx_s != ST_IDLE);
        if (state_nx_s == ST_SWITCH) begin
            sel_nx_s = tgt_r;
        end else begin
            sel_nx_s = sel_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (state_nx_s == ST_IDLE) begin
                    ena_nx_s = ena_r & ena_s;
                end else begin
                    ena_nx_s = 1'b0;
                end
            end
            ST_ENABLE: ena_nx_s = ena_s;
            default:   ena_nx_s = 1'b0;
        endcase
    end

    assign spine_sel  = sel_r;
    assign spine_ena  = ena_r;
    assign busy       = busy_r;
    assign target_sel = tgt_r;

endmodule
